// File: rtl/bypass_scoreboard.sv
// bypass_scoreboard: N-lane pipeline tag tracker (DX/XM/MW) that decides issue
// acceptance at decode, generates one-hot operand and store-data bypass selects,
// and counts stall cycles with saturation.
module bypass_scoreboard #(
  parameter int LANES = 2,
  parameter int AW    = 5,
  parameter int CW    = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     hold,
  input  logic                     flush,
  input  logic [LANES-1:0]         dec_valid,
  input  logic [LANES*AW-1:0]      dec_rs,
  input  logic [LANES*AW-1:0]      dec_rt,
  input  logic [LANES*AW-1:0]      dec_rd,
  input  logic [LANES-1:0]         dec_regwrite,
  input  logic [LANES-1:0]         dec_isload,
  input  logic [LANES-1:0]         dec_isstore,
  output logic [LANES-1:0]         dec_accept,
  output logic                     stall,
  output logic [LANES*2*LANES-1:0] fwd_a,
  output logic [LANES*2*LANES-1:0] fwd_b,
  output logic [LANES*LANES-1:0]   fwd_m,
  output logic [CW-1:0]            stall_cycles
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic          regwrite;
    logic          isload;
    logic          isstore;
  } slot_t;

  slot_t [LANES-1:0] dec_s;
  slot_t [LANES-1:0] dx_q, dx_d, xm_q, xm_d, mw_q, mw_d;
  logic  [CW-1:0]    stall_cycles_q, stall_cycles_d;
  logic  [LANES-1:0] blocked;
  logic              xm_load_hit;

  // r0 is hardwired zero, so a producer targeting it never counts as a write.
  function automatic logic written(input slot_t s);
    return s.valid && s.regwrite && (s.rd != '0);
  endfunction

  // Youngest producer wins: any XM beats any MW, higher lane beats lower lane.
  function automatic logic [2*LANES-1:0] pick_src(input logic [AW-1:0] src,
                                                  input slot_t [LANES-1:0] xm,
                                                  input slot_t [LANES-1:0] mw);
    logic [2*LANES-1:0] sel;
    logic               hit;
    sel = '0;
    hit = 1'b0;
    for (int k = LANES-1; k >= 0; k--) begin
      if (!hit && written(xm[k]) && (xm[k].rd == src)) begin
        sel[k] = 1'b1;
        hit    = 1'b1;
      end
    end
    for (int k = LANES-1; k >= 0; k--) begin
      if (!hit && written(mw[k]) && (mw[k].rd == src)) begin
        sel[LANES+k] = 1'b1;
        hit          = 1'b1;
      end
    end
    return sel;
  endfunction

  // Unpack the flat decode buses into per-lane slots.
  always_comb begin
    dec_s = '0;
    for (int l = 0; l < LANES; l++) begin
      dec_s[l].valid    = dec_valid[l];
      dec_s[l].rs       = dec_rs[l*AW +: AW];
      dec_s[l].rt       = dec_rt[l*AW +: AW];
      dec_s[l].rd       = dec_rd[l*AW +: AW];
      dec_s[l].regwrite = dec_regwrite[l];
      dec_s[l].isload   = dec_isload[l];
      dec_s[l].isstore  = dec_isstore[l];
    end
  end

  // Load-use and intra-bundle interlock; acceptance is a prefix from lane 0.
  always_comb begin
    logic ok;
    blocked    = '0;
    dec_accept = '0;
    ok         = !hold && !flush;
    for (int l = 0; l < LANES; l++) begin
      for (int j = 0; j < LANES; j++) begin
        if (written(dx_q[j]) && dx_q[j].isload &&
            ((dec_s[l].rs == dx_q[j].rd) || (dec_s[l].rt == dx_q[j].rd)))
          blocked[l] = 1'b1;
        if ((j < l) && written(dec_s[j]) &&
            ((dec_s[l].rs == dec_s[j].rd) || (dec_s[l].rt == dec_s[j].rd)))
          blocked[l] = 1'b1;
      end
      ok            = ok && dec_s[l].valid && !blocked[l];
      dec_accept[l] = ok;
    end
    stall = !hold && !flush && ((dec_valid & ~dec_accept) != '0);
  end

  // Operand bypass selects for DX and store-data selects for XM stores.
  always_comb begin
    fwd_a       = '0;
    fwd_b       = '0;
    fwd_m       = '0;
    xm_load_hit = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (dx_q[l].valid) begin
        fwd_a[l*2*LANES +: 2*LANES] = pick_src(dx_q[l].rs, xm_q, mw_q);
        fwd_b[l*2*LANES +: 2*LANES] = pick_src(dx_q[l].rt, xm_q, mw_q);
        for (int k = 0; k < LANES; k++) begin
          if (written(xm_q[k]) && xm_q[k].isload &&
              ((xm_q[k].rd == dx_q[l].rs) || (xm_q[k].rd == dx_q[l].rt)))
            xm_load_hit = 1'b1;
        end
      end
      if (xm_q[l].valid && xm_q[l].isstore) begin
        for (int k = 0; k < LANES; k++) begin
          if (written(mw_q[k]) && mw_q[k].isload && (mw_q[k].rd == xm_q[l].rt)) begin
            fwd_m[l*LANES +: LANES] = '0;
            fwd_m[l*LANES + k]      = 1'b1;
          end
        end
      end
    end
  end

  // Pipeline advance, flush bubbles and saturating stall count.
  always_comb begin
    dx_d           = dx_q;
    xm_d           = xm_q;
    mw_d           = mw_q;
    stall_cycles_d = stall_cycles_q;
    if (!hold) begin
      mw_d = xm_q;
      xm_d = dx_q;
      dx_d = dec_s;
      for (int l = 0; l < LANES; l++) begin
        dx_d[l].valid = dec_accept[l];
        if (flush) xm_d[l].valid = 1'b0;
      end
      if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CW'(1);
    end
  end

  // State registers; reset overrides hold and flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      dx_q           <= '0;
      xm_q           <= '0;
      mw_q           <= '0;
      stall_cycles_q <= '0;
    end else begin
      dx_q           <= dx_d;
      xm_q           <= xm_d;
      mw_q           <= mw_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // The load-use interlock must keep any DX source from ever needing an XM load.
  always_ff @(posedge clock) begin
    if (!reset) assert (!xm_load_hit);
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Bench for bypass_scoreboard: directed scenarios plus randomized traffic checked
// against an age-ordered reference model of the in-flight instructions.
module tb_bypass_scoreboard;
  localparam int L  = 2;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int FW = 2*L*L;

  logic              clock = 1'b0;
  logic              reset, hold, flush;
  logic [L-1:0]      dec_valid, dec_regwrite, dec_isload, dec_isstore;
  logic [L*AW-1:0]   dec_rs, dec_rt, dec_rd;
  logic [L-1:0]      dec_accept, s_accept;
  logic              stall, s_stall;
  logic [FW-1:0]     fwd_a, fwd_b, s_fwd_a, s_fwd_b;
  logic [L*L-1:0]    fwd_m, s_fwd_m;
  logic [CW-1:0]     stall_cycles;
  logic [1:0]        s_stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  bypass_scoreboard #(.LANES(L), .AW(AW), .CW(CW)) dut (
    .clock(clock), .reset(reset), .hold(hold), .flush(flush),
    .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd),
    .dec_regwrite(dec_regwrite), .dec_isload(dec_isload), .dec_isstore(dec_isstore),
    .dec_accept(dec_accept), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .fwd_m(fwd_m), .stall_cycles(stall_cycles)
  );

  bypass_scoreboard #(.LANES(L), .AW(AW), .CW(2)) dut_small (
    .clock(clock), .reset(reset), .hold(hold), .flush(flush),
    .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd),
    .dec_regwrite(dec_regwrite), .dec_isload(dec_isload), .dec_isstore(dec_isstore),
    .dec_accept(s_accept), .stall(s_stall), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .fwd_m(s_fwd_m), .stall_cycles(s_stall_cycles)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    bit v; bit [AW-1:0] rs; bit [AW-1:0] rt; bit [AW-1:0] rd; bit rw; bit ld; bit st;
  } ins_t;

  ins_t m_dx [L];
  ins_t m_xm [L];
  ins_t m_mw [L];
  int   m_cnt = 0;
  int   m_cnt2 = 0;
  bit [L-1:0]   exp_acc;
  bit           exp_stall;
  bit [FW-1:0]  exp_fa, exp_fb;
  bit [L*L-1:0] exp_fm;

  function automatic bit wr(input ins_t i);
    return i.v && i.rw && (i.rd != 0);
  endfunction

  function automatic ins_t dec_lane(input int l);
    ins_t d;
    d.v  = dec_valid[l];
    d.rs = dec_rs[l*AW +: AW];
    d.rt = dec_rt[l*AW +: AW];
    d.rd = dec_rd[l*AW +: AW];
    d.rw = dec_regwrite[l];
    d.ld = dec_isload[l];
    d.st = dec_isstore[l];
    return d;
  endfunction

  function automatic bit lane_ok(input int l);
    ins_t d, e;
    d = dec_lane(l);
    if (!d.v) return 1'b0;
    for (int j = 0; j < L; j++)
      if (wr(m_dx[j]) && m_dx[j].ld &&
          ((d.rs != 0 && d.rs == m_dx[j].rd) || (d.rt != 0 && d.rt == m_dx[j].rd))) return 1'b0;
    for (int j = 0; j < l; j++) begin
      e = dec_lane(j);
      if (wr(e) && (d.rs == e.rd || d.rt == e.rd)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Scan in-flight instructions oldest to youngest; the last match is the source.
  function automatic int youngest(input bit [AW-1:0] src);
    int best = -1;
    if (src == 0) return -1;
    for (int k = 0; k < L; k++) if (wr(m_mw[k]) && m_mw[k].rd == src) best = L + k;
    for (int k = 0; k < L; k++) if (wr(m_xm[k]) && m_xm[k].rd == src) best = k;
    return best;
  endfunction

  task automatic model_eval();
    int n = 0;
    int k;
    if (!hold && !flush) while (n < L && lane_ok(n)) n++;
    exp_acc   = L'((1 << n) - 1);
    exp_stall = !hold && !flush && ((dec_valid & ~exp_acc) != 0);
    exp_fa = '0; exp_fb = '0; exp_fm = '0;
    for (int l = 0; l < L; l++) begin
      if (m_dx[l].v) begin
        k = youngest(m_dx[l].rs); if (k >= 0) exp_fa[l*2*L + k] = 1'b1;
        k = youngest(m_dx[l].rt); if (k >= 0) exp_fb[l*2*L + k] = 1'b1;
      end
      if (m_xm[l].v && m_xm[l].st) begin
        k = -1;
        for (int j = 0; j < L; j++) if (wr(m_mw[j]) && m_mw[j].ld && m_mw[j].rd == m_xm[l].rt) k = j;
        if (k >= 0) exp_fm[l*L + k] = 1'b1;
      end
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      for (int l = 0; l < L; l++) begin m_dx[l] = '0; m_xm[l] = '0; m_mw[l] = '0; end
      m_cnt = 0; m_cnt2 = 0;
    end else if (!hold) begin
      if (exp_stall) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      for (int l = 0; l < L; l++) begin
        m_mw[l] = m_xm[l];
        m_xm[l] = m_dx[l];
        if (flush) m_xm[l].v = 1'b0;
        m_dx[l] = dec_lane(l);
        m_dx[l].v = exp_acc[l];
      end
    end
  endtask

  // ---------------- drive helpers ----------------
  task automatic settle(); #4; model_eval(); endtask
  task automatic tick(); model_eval(); @(posedge clock); model_edge(); #1; endtask

  task automatic clear_dec();
    dec_valid = '0; dec_rs = '0; dec_rt = '0; dec_rd = '0;
    dec_regwrite = '0; dec_isload = '0; dec_isstore = '0;
  endtask

  task automatic set_lane(input int l, input int rs, input int rt, input int rd,
                          input bit rw, input bit ld, input bit st);
    dec_valid[l] = 1'b1;
    dec_rs[l*AW +: AW] = AW'(rs);
    dec_rt[l*AW +: AW] = AW'(rt);
    dec_rd[l*AW +: AW] = AW'(rd);
    dec_regwrite[l] = rw; dec_isload[l] = ld; dec_isstore[l] = st;
  endtask

  task automatic drain();
    clear_dec(); hold = 0; flush = 0;
    repeat (3) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1; hold = 1; flush = 1;
    set_lane(0, 9, 0, 9, 1, 1, 0);
    tick(); tick();
    reset = 0; hold = 0; flush = 0;
    clear_dec(); set_lane(0, 1, 2, 3, 1, 0, 0); set_lane(1, 5, 6, 4, 1, 0, 0);
    settle();
    vectors++; if (fwd_a !== '0 || fwd_b !== '0) begin miscompares++;
      $display("FAIL reset_fwd_ab got a=%h b=%h exp 0", fwd_a, fwd_b); end
    vectors++; if (fwd_m !== '0) begin miscompares++; $display("FAIL reset_fwd_m got=%h exp 0", fwd_m); end
    vectors++; if (stall !== 1'b0 || stall_cycles !== '0) begin miscompares++;
      $display("FAIL reset_stall got stall=%b cnt=%0d exp 0/0", stall, stall_cycles); end
    vectors++; if (dec_accept !== 2'b11) begin miscompares++;
      $display("FAIL reset_accept got=%b exp=11", dec_accept); end
  endtask

  task automatic test_independent();
    drain();
    set_lane(0, 1, 2, 3, 1, 0, 0); set_lane(1, 5, 6, 4, 1, 0, 0);
    settle();
    vectors++; if (dec_accept !== 2'b11 || stall !== 1'b0) begin miscompares++;
      $display("FAIL indep_accept got acc=%b stall=%b exp 11/0", dec_accept, stall); end
    tick(); clear_dec(); settle();
    vectors++; if (fwd_a !== '0 || fwd_b !== '0) begin miscompares++;
      $display("FAIL indep_fwd got a=%h b=%h exp 0", fwd_a, fwd_b); end
  endtask

  task automatic test_back_to_back();
    drain();
    set_lane(0, 1, 2, 3, 0, 0, 0); set_lane(1, 1, 2, 7, 1, 0, 0);
    tick(); clear_dec(); set_lane(0, 7, 0, 10, 1, 0, 0); settle();
    vectors++; if (dec_accept !== 2'b01) begin miscompares++;
      $display("FAIL b2b_accept got=%b exp=01", dec_accept); end
    tick(); clear_dec(); settle();
    vectors++; if (fwd_a !== 8'h02 || fwd_b !== '0) begin miscompares++;
      $display("FAIL b2b_fwd_xm got a=%h b=%h exp 02/00", fwd_a, fwd_b); end
    drain();
    set_lane(0, 1, 2, 3, 0, 0, 0); set_lane(1, 1, 2, 7, 1, 0, 0);
    tick(); clear_dec(); tick();
    set_lane(0, 7, 0, 10, 1, 0, 0); tick(); clear_dec(); settle();
    vectors++; if (fwd_a !== 8'h08) begin miscompares++;
      $display("FAIL gap_fwd_mw got=%h exp=08", fwd_a); end
  endtask

  task automatic test_load_use();
    int base;
    drain();
    set_lane(0, 1, 0, 9, 1, 1, 0);
    tick(); clear_dec(); set_lane(0, 2, 9, 11, 1, 0, 0); settle();
    vectors++; if (dec_accept !== 2'b00 || stall !== 1'b1) begin miscompares++;
      $display("FAIL lu_block got acc=%b stall=%b exp 00/1", dec_accept, stall); end
    base = m_cnt;
    tick(); settle();
    vectors++; if (stall_cycles !== CW'(base + 1)) begin miscompares++;
      $display("FAIL lu_count got=%0d exp=%0d", stall_cycles, base + 1); end
    vectors++; if (dec_accept !== 2'b01 || stall !== 1'b0) begin miscompares++;
      $display("FAIL lu_release got acc=%b stall=%b exp 01/0", dec_accept, stall); end
    tick(); clear_dec(); settle();
    vectors++; if (fwd_b !== 8'h04 || fwd_a !== '0) begin miscompares++;
      $display("FAIL lu_fwd got a=%h b=%h exp 00/04", fwd_a, fwd_b); end
  endtask

  task automatic test_intra();
    drain();
    set_lane(0, 1, 1, 2, 1, 0, 0); set_lane(1, 2, 3, 12, 1, 0, 0); settle();
    vectors++; if (dec_accept !== 2'b01 || stall !== 1'b1) begin miscompares++;
      $display("FAIL intra_block got acc=%b stall=%b exp 01/1", dec_accept, stall); end
    tick(); clear_dec(); set_lane(0, 2, 3, 12, 1, 0, 0); settle();
    vectors++; if (dec_accept !== 2'b01) begin miscompares++;
      $display("FAIL intra_repr got=%b exp=01", dec_accept); end
    tick(); clear_dec(); settle();
    vectors++; if (fwd_a !== 8'h01) begin miscompares++;
      $display("FAIL intra_fwd got=%h exp=01", fwd_a); end
  endtask

  task automatic test_priority();
    drain();
    set_lane(0, 1, 1, 3, 0, 0, 0); set_lane(1, 1, 1, 5, 1, 0, 0);
    tick(); clear_dec(); set_lane(0, 1, 1, 5, 1, 0, 0);
    tick(); clear_dec(); set_lane(0, 5, 0, 13, 1, 0, 0);
    tick(); clear_dec(); settle();
    vectors++; if (fwd_a !== 8'h01) begin miscompares++;
      $display("FAIL prio_xm_over_mw got=%h exp=01", fwd_a); end
    drain();
    set_lane(0, 1, 1, 0, 1, 0, 0);
    tick(); clear_dec(); set_lane(0, 0, 0, 14, 1, 0, 0);
    tick(); clear_dec(); settle();
    vectors++; if (fwd_a !== '0 || fwd_b !== '0) begin miscompares++;
      $display("FAIL r0_nosel got a=%h b=%h exp 0", fwd_a, fwd_b); end
  endtask

  // A store can never trail its load by exactly one stage (the interlock holds it),
  // so its data arrives through fwd_b and fwd_m stays clear.
  task automatic test_store_data();
    drain();
    set_lane(0, 1, 0, 8, 1, 1, 0);
    tick(); clear_dec(); set_lane(0, 3, 8, 0, 0, 0, 1); settle();
    vectors++; if (dec_accept !== 2'b00 || stall !== 1'b1) begin miscompares++;
      $display("FAIL st_block got acc=%b stall=%b exp 00/1", dec_accept, stall); end
    tick(); tick(); clear_dec(); settle();
    vectors++; if (fwd_b !== 8'h04 || fwd_m !== '0) begin miscompares++;
      $display("FAIL st_fwd got b=%h m=%h exp 04/0", fwd_b, fwd_m); end
  endtask

  task automatic test_hold();
    int base;
    drain();
    set_lane(0, 1, 2, 3, 0, 0, 0); set_lane(1, 1, 2, 7, 1, 0, 0);
    tick(); clear_dec(); set_lane(0, 7, 0, 10, 1, 0, 0); tick();
    base = m_cnt;
    hold = 1; clear_dec(); set_lane(0, 1, 2, 3, 1, 0, 0); set_lane(1, 3, 0, 4, 1, 0, 0);
    for (int c = 0; c < 3; c++) begin
      settle();
      vectors++; if (dec_accept !== 2'b00 || stall !== 1'b0 || fwd_a !== 8'h02) begin miscompares++;
        $display("FAIL hold_frozen c=%0d got acc=%b stall=%b a=%h exp 00/0/02", c, dec_accept, stall, fwd_a); end
      vectors++; if (stall_cycles !== CW'(base)) begin miscompares++;
        $display("FAIL hold_count got=%0d exp=%0d", stall_cycles, base); end
      tick();
    end
    hold = 0;
  endtask

  task automatic test_flush();
    drain();
    set_lane(0, 1, 2, 3, 0, 0, 0); set_lane(1, 1, 2, 7, 1, 0, 0);
    tick(); flush = 1; clear_dec(); set_lane(0, 7, 0, 10, 1, 0, 0); settle();
    vectors++; if (dec_accept !== 2'b00 || stall !== 1'b0) begin miscompares++;
      $display("FAIL flush_accept got acc=%b stall=%b exp 00/0", dec_accept, stall); end
    tick(); flush = 0; settle();
    vectors++; if (dec_accept !== 2'b01) begin miscompares++;
      $display("FAIL flush_after got=%b exp=01", dec_accept); end
    tick(); clear_dec(); settle();
    vectors++; if (fwd_a !== '0) begin miscompares++;
      $display("FAIL flush_bubble got=%h exp=00", fwd_a); end
  endtask

  task automatic test_saturate();
    reset = 1; tick(); reset = 0;
    clear_dec(); set_lane(0, 1, 1, 2, 1, 0, 0); set_lane(1, 2, 3, 12, 1, 0, 0);
    repeat (5) tick();
    clear_dec(); settle();
    vectors++; if (s_stall_cycles !== 2'd3 || stall_cycles !== 16'd5) begin miscompares++;
      $display("FAIL sat_count got small=%0d big=%0d exp 3/5", s_stall_cycles, stall_cycles); end
    reset = 1; tick(); reset = 0; settle();
    vectors++; if (s_stall_cycles !== 2'd0 || stall_cycles !== '0 || fwd_a !== '0) begin miscompares++;
      $display("FAIL sat_reset got small=%0d big=%0d a=%h exp 0", s_stall_cycles, stall_cycles, fwd_a); end
  endtask

  task automatic test_random();
    reset = 1; tick(); reset = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom % 64) == 0;
      hold  = ($urandom % 8) == 0;
      flush = ($urandom % 16) == 0;
      clear_dec();
      for (int l = 0; l < L; l++)
        if (($urandom % 10) < 8)
          set_lane(l, $urandom % 6, $urandom % 6, $urandom % 6,
                   ($urandom % 10) < 7, ($urandom % 10) < 3, ($urandom % 10) < 2);
      settle();
      vectors++; if (dec_accept !== exp_acc || stall !== exp_stall) begin miscompares++;
        $display("FAIL rnd_accept c=%0d got acc=%b stall=%b exp %b/%b", c, dec_accept, stall, exp_acc, exp_stall); end
      vectors++; if (fwd_a !== exp_fa || fwd_b !== exp_fb) begin miscompares++;
        $display("FAIL rnd_fwd c=%0d got a=%h b=%h exp %h/%h", c, fwd_a, fwd_b, exp_fa, exp_fb); end
      vectors++; if (fwd_m !== exp_fm) begin miscompares++;
        $display("FAIL rnd_fwd_m c=%0d got=%h exp=%h", c, fwd_m, exp_fm); end
      vectors++; if (stall_cycles !== CW'(m_cnt) || s_stall_cycles !== 2'(m_cnt2)) begin miscompares++;
        $display("FAIL rnd_count c=%0d got big=%0d small=%0d exp %0d/%0d", c, stall_cycles, s_stall_cycles, m_cnt, m_cnt2); end
      tick();
    end
    reset = 0; hold = 0; flush = 0;
  endtask

  initial begin
    reset = 1; hold = 0; flush = 0;
    clear_dec();
    for (int l = 0; l < L; l++) begin m_dx[l] = '0; m_xm[l] = '0; m_mw[l] = '0; end
    #1;
    test_reset();
    test_independent();
    test_back_to_back();
    test_load_use();
    test_intra();
    test_priority();
    test_store_data();
    test_hold();
    test_flush();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
